// File: rtl/frame_scan_ctrl.sv
// Purpose: loads a W-bit frame, streams it MSB-first through a "01"-edge detector and counts the hits.
// Latency: busy for W+1 cycles after the accept edge; done pulses W cycles after accept; one frame per W+2 cycles.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) while busy, including the DONE cycle.
module frame_scan_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [W-1:0]  data,
  output logic          busy,
  output logic          hit,
  output logic          done,
  output logic [CW-1:0] count
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [2:0]    det;
  logic [2:0]    det_nxt;
  logic          det_out;
  logic [W-1:0]  sreg;
  logic [IW-1:0] idx;
  logic          accept;
  logic          cur_bit;

  assign accept  = (state == ST_IDLE) && start;
  assign cur_bit = sreg[W-1];

  // Controller state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Controller next-state: leave SHIFT on the edge that consumes the last bit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (idx == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Controller outputs; hit is only meaningful while bits are being presented
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    hit  = (state == ST_SHIFT) && det_out;
  end

  // Mealy "01" detector: S1 marks one leading zero, so an edge at bit 1 cannot hit
  always_comb begin
    det_nxt = S0;
    det_out = 1'b0;
    case (det)
      S0: det_nxt = cur_bit ? S3 : S1;
      S1: det_nxt = cur_bit ? S3 : S2;
      S2: begin
        det_nxt = cur_bit ? S3 : S2;
        det_out = cur_bit;
      end
      S3: det_nxt = cur_bit ? S3 : S4;
      S4: begin
        det_nxt = cur_bit ? S3 : S2;
        det_out = cur_bit;
      end
      default: begin
        det_nxt = S0;
        det_out = 1'b0;
      end
    endcase
  end

  // Datapath: load on accept, shift/advance/count once per SHIFT cycle
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sreg  <= '0;
      idx   <= '0;
      count <= '0;
      det   <= S0;
    end else if (accept) begin
      sreg  <= data;
      idx   <= '0;
      count <= '0;
      det   <= S0;
    end else if (state == ST_SHIFT) begin
      sreg <= {sreg[W-2:0], 1'b0};
      idx  <= idx + 1'b1;
      det  <= det_nxt;
      if (hit && (count != {CW{1'b1}})) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
